// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory loader and any
// host-side frame generator: geometry, checksum width, FSM codes.
package imem_loader_pkg;

    localparam int DEPTH_DEF = 1024;
    localparam int AW_DEF    = 10;
    localparam int DW_DEF    = 16;
    localparam int CSUM_W    = 16;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEN   = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_CSUM  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERROR = 3'd5;

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one synchronous write port, one
// asynchronous read port. Contents are never reset.
module imem_array
    import imem_loader_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Framed program loader: LEN, N payload words, checksum.
// Owns the instruction memory and gates fetch while busy.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [15:0]   PC,
    output logic [DW-1:0] Outins,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW:0]   words_loaded
);

    logic [2:0]        state;
    logic [AW-1:0]     addr;
    logic [CSUM_W-1:0] sum;
    logic [DW-1:0]     len;
    logic [AW:0]       wl_next;
    logic              xfer;
    logic              we;
    logic [DW-1:0]     rdata;
    logic              unused_pc;

    assign in_ready = (state == S_LEN) || (state == S_DATA) ||
                      (state == S_CSUM);
    assign busy     = in_ready;
    assign xfer     = in_valid && in_ready;
    assign wl_next  = words_loaded + 1'b1;

    // start wins over a coincident transfer, so no write then
    assign we = xfer && !start && (state == S_DATA);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            addr         <= '0;
            sum          <= '0;
            len          <= '0;
            words_loaded <= '0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else if (start) begin
            state        <= S_LEN;
            addr         <= '0;
            sum          <= '0;
            words_loaded <= '0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else if (xfer) begin
            case (state)
                S_LEN: begin
                    len <= in_data;
                    if (in_data == '0) begin
                        state <= S_CSUM;
                    end else if (in_data > DW'(DEPTH)) begin
                        state <= S_ERROR;
                        err   <= 1'b1;
                    end else begin
                        state <= S_DATA;
                    end
                end
                S_DATA: begin
                    addr         <= addr + 1'b1;
                    sum          <= sum + CSUM_W'(in_data);
                    words_loaded <= wl_next;
                    if (DW'(wl_next) == len) begin
                        state <= S_CSUM;
                    end
                end
                S_CSUM: begin
                    if (CSUM_W'(in_data) == sum) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= S_ERROR;
                        err   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    imem_array #(
        .DEPTH(DEPTH),
        .AW   (AW),
        .DW   (DW)
    ) u_array (
        .clk  (clk),
        .we   (we),
        .waddr(addr),
        .wdata(in_data),
        .raddr(PC[AW-1:0]),
        .rdata(rdata)
    );

    // upper PC bits deliberately wrap
    assign unused_pc = ^PC[15:AW];

    assign Outins = busy ? '0 : rdata;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framed loads, errors,
// gapped handshake, restart and reset with fixed expectations.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] PC;
    logic [15:0] Outins;
    logic        busy;
    logic        done;
    logic        err;
    logic [10:0] words_loaded;

    int checks = 0;
    int errors = 0;

    imem_loader dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .PC          (PC),
        .Outins      (Outins),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [15:0] w);
        in_valid = 1'b1;
        in_data  = w;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 16'hdead;
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        in_data  = 16'hbeef;
        @(negedge clk);
    endtask

    task automatic rd(input string tag, input logic [15:0] pc,
                      input logic [15:0] exp);
        PC = pc;
        #1;
        chk(tag, Outins, exp);
    endtask

    initial begin
        logic [15:0] frame1 [5];
        frame1 = '{16'd3, 16'd9, 16'd1, 16'd2, 16'd12};
        reset    = 1'b1;
        start    = 1'b0;
        in_data  = '0;
        in_valid = 1'b0;
        PC       = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_rdy", in_ready, 0);
        chk("rst_wl", words_loaded, 0);

        // normal load
        do_start();
        for (int i = 0; i < 5; i++) begin
            chk("ld_busy", busy, 1);
            chk("ld_out0", Outins, 0);
            send(frame1[i]);
        end
        chk("ld_done", done, 1);
        chk("ld_err", err, 0);
        chk("ld_wl", words_loaded, 3);
        chk("ld_busy_end", busy, 0);
        chk("ld_rdy_end", in_ready, 0);
        rd("ld_pc0", 16'd0, 16'd9);
        rd("ld_pc1", 16'd1, 16'd1);
        rd("ld_pc2", 16'd2, 16'd2);

        // bad checksum
        do_start();
        chk("bc_clr_done", done, 0);
        send(16'd2);
        send(16'd5);
        send(16'd6);
        send(16'd10);
        chk("bc_err", err, 1);
        chk("bc_done", done, 0);
        chk("bc_rdy", in_ready, 0);
        chk("bc_busy", busy, 0);
        chk("bc_wl", words_loaded, 2);
        rd("bc_pc1", 16'd1, 16'd6);

        // length overflow
        do_start();
        chk("ov_clr_err", err, 0);
        send(16'd1025);
        chk("ov_err", err, 1);
        chk("ov_busy", busy, 0);
        chk("ov_wl", words_loaded, 0);
        rd("ov_pc0", 16'd0, 16'd5);

        // gapped handshake
        do_start();
        send(16'd2);
        idle_cycle();
        idle_cycle();
        send(16'd7);
        idle_cycle();
        idle_cycle();
        chk("gap_wl", words_loaded, 1);
        chk("gap_busy", busy, 1);
        send(16'd8);
        idle_cycle();
        chk("gap_notdone", done, 0);
        send(16'd15);
        chk("gap_done", done, 1);
        chk("gap_err", err, 0);
        rd("gap_wrap", 16'h0401, 16'd8);
        rd("gap_pc0", 16'd0, 16'd7);

        // zero-length frame
        do_start();
        send(16'd0);
        chk("z_busy", busy, 1);
        send(16'd0);
        chk("z_done", done, 1);
        chk("z_wl", words_loaded, 0);

        // restart mid-frame, coincident word dropped
        do_start();
        send(16'd4);
        send(16'd1);
        send(16'd2);
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'd99;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        chk("rs_rdy", in_ready, 1);
        chk("rs_wl", words_loaded, 0);
        chk("rs_busy", busy, 1);
        send(16'd1);
        send(16'd3);
        send(16'd3);
        chk("rs_done", done, 1);
        chk("rs_wl1", words_loaded, 1);
        rd("rs_pc0", 16'd0, 16'd3);
        rd("rs_pc1", 16'd1, 16'd2);

        // reset mid-load
        do_start();
        send(16'd3);
        send(16'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rm_busy", busy, 0);
        chk("rm_done", done, 0);
        chk("rm_err", err, 0);
        chk("rm_rdy", in_ready, 0);
        chk("rm_wl", words_loaded, 0);
        rd("rm_pc0", 16'd0, 16'd1);
        send(16'd5);
        chk("rm_idle_rdy", in_ready, 0);
        chk("rm_idle_wl", words_loaded, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart of the instruction-fetch path: accepts a framed program image as a stream of 16-bit words and writes it into a 1024x16 instruction memory.
- The memory is owned by this block.
- The fetch side reads the same memory asynchronously by PC once loading completes.
- Sits between an external host/boot source and the program counter / instruction-decode path; holds the CPU (busy) while a load is in progress.

Parameters:
DEPTH, 1024, number of instruction words in the memory
AW, 10, address width (log2 DEPTH); fetch uses PC[AW-1:0]
DW, 16, instruction/data word width

Ports:
clk  input  1  system clock; all state changes on posedge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse: begin (or restart) a load frame
in_data  input  DW  stream word from host
in_valid  input  1  in_data is valid this cycle
in_ready  output  1  loader accepts a word this cycle
PC  input  16  fetch address from program counter
Outins  output  DW  instruction at PC[AW-1:0]; 0 while busy
busy  output  1  load frame in progress (states LEN, DATA, CSUM)
done  output  1  sticky: last frame completed with matching checksum
err  output  1  sticky: last frame failed (bad length or checksum)
words_loaded  output  AW+1  payload words written in current/last frame

Behaviour:
- Transfer occurs on a posedge where in_valid && in_ready (handshake "xfer"). in_ready is a pure function of state: 1 in LEN, DATA and CSUM; 0 otherwise. in_data is ignored without xfer.
- Frame format: word0 = N (payload length), words 1..N = instructions written to addresses 0..N-1, final word = checksum (16-bit wrap-around sum of the N payload words).
- States: IDLE, LEN, DATA, CSUM, DONE, ERROR.
- IDLE: start -> LEN.
- LEN: on xfer latch N = in_data. N == 0 -> CSUM (expected sum 0). 1 <= N <= DEPTH -> DATA. N > DEPTH -> ERROR. No memory write occurs in LEN.
- DATA: on xfer, mem[addr] <= in_data, addr++, sum += in_data (mod 2^16), words_loaded++. After the Nth word -> CSUM.
- CSUM: on xfer, in_data == sum -> DONE (done=1); otherwise -> ERROR (err=1).
- DONE / ERROR: hold until start or reset.
- start in any state, including mid-frame, restarts the frame: next state LEN, addr=0, sum=0, words_loaded=0, done=0, err=0. start takes priority over a simultaneous xfer; that word is dropped and in_ready is ignored that cycle.
- Memory writes already made by an aborted frame are retained. No write occurs on the start cycle.
- Reset values: state IDLE, addr 0, sum 0, N 0, words_loaded 0, done 0, err 0, in_ready 0, busy 0.
- Reset does not clear memory contents. Reset mid-load leaves partially written words in place.
- Outins = busy ? 0 : mem[PC[AW-1:0]]. This read is combinational, zero latency, and reflects a DATA write from the following cycle onward. PC bits above AW-1 are ignored (address wrap).
- Memory is writable only through the DATA state. No other write path exists.
- words_loaded saturates naturally at DEPTH (width AW+1 holds 1024).
- Latency: a frame of N words with in_valid held high completes in N+2 xfer cycles after the start cycle. done/err are visible the cycle after the CSUM xfer.

Decomposition:
- Shared package: state encoding (IDLE..ERROR as localparams), DEPTH/AW/DW defaults, and the checksum width constant, shared with any future host-side frame generator.
- One natural sub-module, imem_array: DEPTH x DW storage with one synchronous write port and one asynchronous read port.
- The loader FSM, counters and checksum accumulator stay in imem_loader.

Test Plan:
- Normal load: start; stream 3, 9, 1, 2, 12 with in_valid=1 -> done=1 after 5 xfers, err=0, words_loaded=3; PC=0,1,2 -> Outins 9, 1, 2; busy was 1 throughout the load and Outins=0 while busy.
- Bad checksum: start; stream 2, 5, 6, 10 -> err=1, done=0, state ERROR, in_ready=0; PC=1 -> Outins 6 (written words retained).
- Length overflow: start; stream 1025 -> ERROR, err=1, words_loaded=0, no memory write.
- Gapped handshake: in_valid toggled 1,0,0,1 between words of the frame 2, 7, 8, 15 -> only asserted cycles advance; done=1, Outins at PC=16'h0401 (wraps to 1) = 8.
- Restart mid-frame: start; 4, 1, 2; then start asserted with in_valid=1 on the same cycle -> word dropped, state LEN; then 1, 3, 3 -> done=1, words_loaded=1, Outins at PC=0 = 3.
- Reset mid-load: after 3, 1 -> reset -> busy=0, done=0, err=0, in_ready=0, state IDLE; PC=0 -> Outins 1.
